bj_resolve: RTL and testbench
=============================

Name: bj_resolve

Overview:
- Execute-stage branch/jump resolution unit. Produces the bj_en / bj_pc redirect that the execute debug monitor and the fetch PC generator consume.
- Evaluates the six conditional branches plus jal/jalr and computes the link value, the target and misalignment.
- Registers the outcome and holds the redirect until fetch acknowledges it.
- Then asserts a flush for a fixed number of cycles to kill younger wrong-path instructions.

Parameters:
- FLUSH_DEPTH, 2, cycles flush stays high after a redirect is acknowledged (legal range 1..7).
- RESET_PC, 64'h0, reset value of bj_pc and out_pc.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline stall; freezes the input capture
- in_valid  in  1  an instruction is presented this cycle
- pc  in  64  instruction PC
- rd  in  5  destination register
- data1  in  64  rs1 value
- data2  in  64  rs2 value
- imm  in  64  sign-extended immediate
- bj_op  in  8  op vector {beq,bne,blt,bge,bltu,bgeu,jal,jalr}; one-hot or zero
- redirect_ack  in  1  fetch has accepted bj_pc
- out_valid  out  1  registered instruction valid
- out_pc  out  64  registered PC
- out_rd  out  5  registered rd
- result  out  64  link value pc+4 for jal/jalr, else 0
- bj_en  out  1  redirect request (level, held until ack)
- bj_pc  out  64  redirect target
- misalign  out  1  one-cycle pulse: taken target has bit1 set
- flush  out  1  kill younger instructions
- busy  out  1  state != IDLE; upstream must stall

Behaviour:
- Reset values: all outputs 0, except bj_pc = out_pc = RESET_PC. State = IDLE.
- Capture condition: in_valid & ~stall & ~busy.
  - On capture, register pc, rd and the result one cycle later; out_valid = 1 for that cycle.
  - On any other cycle, out_valid = 0.
- Taken conditions:
  - beq: data1 == data2. bne: inverse of beq.
  - blt / bge: signed 64-bit compare.
  - bltu / bgeu: unsigned compare.
  - jal and jalr: always taken.
- Target calculation (64-bit, wrap-around modulo 2^64, no overflow flag):
  - Branch and jal: pc + imm.
  - jalr: (data1 + imm) & ~64'h1.
- Misaligned target (target[1] == 1 on a taken op):
  - misalign pulses for 1 cycle alongside out_valid.
  - No redirect is issued; state stays IDLE.
- Not taken: bj_en stays 0; state stays IDLE.
- State machine:
  - IDLE -> REDIRECT when a taken, aligned op is captured. bj_en = 1 and bj_pc = target in the same cycle as out_valid (1-cycle latency from capture).
  - REDIRECT: bj_en and bj_pc hold stable. On redirect_ack, go to FLUSH, bj_en -> 0, and load the counter with FLUSH_DEPTH.
  - FLUSH: flush = 1; the counter decrements each cycle. When the counter reaches 1, go to IDLE next cycle, so flush is high for exactly FLUSH_DEPTH cycles.
- redirect_ack outside REDIRECT is ignored.
- redirect_ack arriving in the same cycle bj_en first rises is honoured: the next cycle is FLUSH.
- stall does not affect REDIRECT or FLUSH progress; it only blocks capture.
- Asynchronous reset mid-REDIRECT or mid-FLUSH: immediately returns to IDLE with all outputs at reset values. No pending redirect survives.
- An illegal bj_op (more than 1 bit set) is treated as not taken; result = 0.

Optional Feature:
- Macro BJ_STATS_EN.
- When defined:
  - Adds outputs stat_taken[31:0], stat_nottaken[31:0] and stat_mispredict_cycles[31:0].
  - The first two count captured conditional branches by outcome; jal/jalr count as taken.
  - The third counts cycles spent in REDIRECT or FLUSH.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- beq, data1 = data2 = 5, pc = 64'h1000, imm = 64'h20, ack 2 cycles later -> bj_en = 1 with bj_pc = 64'h1020 for 3 cycles, then flush high for exactly 2 cycles, busy low afterwards.
- blt vs bltu with data1 = 64'hFFFF_FFFF_FFFF_FFFF, data2 = 1 -> blt taken, bltu not taken (bj_en stays 0, out_valid = 1).
- jalr, data1 = 64'h2003, imm = 0, pc = 64'h3000, rd = 1 -> bj_pc = 64'h2002, misalign = 1, bj_en = 0, result = 64'h3004.
- jal, pc = 64'hFFFF_FFFF_FFFF_FFFC, imm = 8 -> bj_pc = 64'h4 (wrap), result = 64'h0.
- redirect_ack on the same cycle bj_en rises, with a new in_valid during FLUSH -> the new instruction is not captured until busy = 0; rst_n pulled low during FLUSH -> flush = 0 and bj_pc = RESET_PC immediately.
- BJ_STATS_EN: 3 taken and 2 not-taken branches with an immediate ack -> stat_taken = 3, stat_nottaken = 2, stat_mispredict_cycles = 3 × (1 + FLUSH_DEPTH) = 9.

Source files
------------

// File: rtl/bj_resolve_if.sv
// Execute-stage branch resolution bundle: instruction in, registered outcome and redirect out.
// Optional statistics signals exist only when BJ_STATS_EN is defined.
interface bj_resolve_if;
  logic        stall;
  logic        in_valid;
  logic [63:0] pc;
  logic [4:0]  rd;
  logic [63:0] data1;
  logic [63:0] data2;
  logic [63:0] imm;
  logic [7:0]  bj_op;
  logic        redirect_ack;

  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic [63:0] result;
  logic        bj_en;
  logic [63:0] bj_pc;
  logic        misalign;
  logic        flush;
  logic        busy;
`ifdef BJ_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_nottaken;
  logic [31:0] stat_mispredict_cycles;
`endif

  modport master (
`ifdef BJ_STATS_EN
    input  stat_taken, stat_nottaken, stat_mispredict_cycles,
`endif
    output stall, in_valid, pc, rd, data1, data2, imm, bj_op, redirect_ack,
    input  out_valid, out_pc, out_rd, result, bj_en, bj_pc, misalign, flush, busy
  );

  modport slave (
`ifdef BJ_STATS_EN
    output stat_taken, stat_nottaken, stat_mispredict_cycles,
`endif
    input  stall, in_valid, pc, rd, data1, data2, imm, bj_op, redirect_ack,
    output out_valid, out_pc, out_rd, result, bj_en, bj_pc, misalign, flush, busy
  );
endinterface

// File: rtl/bj_resolve.sv
// Branch/jump resolution: evaluates the op, holds the redirect until acked, then flushes.
// Define BJ_STATS_EN to add saturating taken/not-taken/mispredict-cycle counters.
module bj_resolve #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input logic         clk,
  input logic         rst_n,
  bj_resolve_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        out_valid_q, misalign_q;
  logic [63:0] out_pc_q, result_q, bj_pc_q;
  logic [4:0]  out_rd_q;

  logic        capture, taken, is_jump;
  logic [63:0] target, link;

  assign capture = bus.in_valid & ~bus.stall & (state_q == ST_IDLE);

  // Only exact one-hot encodings match; zero or multi-hot ops fall to not-taken.
  always_comb begin
    taken   = 1'b0;
    is_jump = 1'b0;
    case (bus.bj_op)
      8'h80:   taken = (bus.data1 == bus.data2);
      8'h40:   taken = (bus.data1 != bus.data2);
      8'h20:   taken = ($signed(bus.data1) <  $signed(bus.data2));
      8'h10:   taken = ($signed(bus.data1) >= $signed(bus.data2));
      8'h08:   taken = (bus.data1 <  bus.data2);
      8'h04:   taken = (bus.data1 >= bus.data2);
      8'h02:   begin taken = 1'b1; is_jump = 1'b1; end
      8'h01:   begin taken = 1'b1; is_jump = 1'b1; end
      default: taken = 1'b0;
    endcase
  end

  assign target = (bus.bj_op == 8'h01) ? ((bus.data1 + bus.imm) & ~64'h1)
                                       : (bus.pc + bus.imm);
  assign link   = is_jump ? (bus.pc + 64'd4) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:
        if (capture && taken && !target[1]) state_d = ST_REDIRECT;
      ST_REDIRECT:
        if (bus.redirect_ack) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      ST_FLUSH:
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_rd_q    <= '0;
      result_q    <= '0;
      misalign_q  <= 1'b0;
      bj_pc_q     <= RESET_PC;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= capture;
      misalign_q  <= capture & taken & target[1];
      if (capture) begin
        out_pc_q <= bus.pc;
        out_rd_q <= bus.rd;
        result_q <= link;
      end
      // bj_pc also reflects a misaligned target so the fault address is visible.
      if (capture && taken) bj_pc_q <= target;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.result    = result_q;
  assign bus.misalign  = misalign_q;
  assign bus.bj_pc     = bj_pc_q;
  assign bus.bj_en     = (state_q == ST_REDIRECT);
  assign bus.flush     = (state_q == ST_FLUSH);
  assign bus.busy      = (state_q != ST_IDLE);

`ifdef BJ_STATS_EN
  logic [31:0] stat_taken_q, stat_nottaken_q, stat_mis_q;
  logic        op_valid;

  assign op_valid = $onehot(bus.bj_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q    <= '0;
      stat_nottaken_q <= '0;
      stat_mis_q      <= '0;
    end else begin
      if (capture && op_valid && taken && stat_taken_q != '1)
        stat_taken_q <= stat_taken_q + 32'd1;
      if (capture && op_valid && !taken && stat_nottaken_q != '1)
        stat_nottaken_q <= stat_nottaken_q + 32'd1;
      if (state_q != ST_IDLE && stat_mis_q != '1)
        stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bus.stat_taken             = stat_taken_q;
  assign bus.stat_nottaken          = stat_nottaken_q;
  assign bus.stat_mispredict_cycles = stat_mis_q;
`endif

endmodule

// File: tb/tb_bj_resolve.sv
// Scoreboard bench for bj_resolve: expected outcomes queued at issue, checked at out_valid.
module tb_bj_resolve;
  localparam int unsigned FLUSH_D = 2;
  localparam logic [63:0] RST_PC  = 64'h8000;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        mis;
    logic        redir;
    logic [63:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  bj_resolve_if bus();

  bj_resolve #(.FLUSH_DEPTH(FLUSH_D), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] op, input logic [63:0] p,
                                 input logic [4:0] r, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] i);
    exp_t e;
    logic tk;
    logic [63:0] t;
    case (op)
      8'h80:   tk = (a == b);
      8'h40:   tk = (a != b);
      8'h20:   tk = ($signed(a) < $signed(b));
      8'h10:   tk = !($signed(a) < $signed(b));
      8'h08:   tk = (a < b);
      8'h04:   tk = !(a < b);
      8'h02,
      8'h01:   tk = 1'b1;
      default: tk = 1'b0;
    endcase
    t = (op == 8'h01) ? {a[63:1] + i[63:1] + {63'd0, a[0] & i[0]}, 1'b0} : p + i;
    e.pc     = p;
    e.rd     = r;
    e.result = (op == 8'h02 || op == 8'h01) ? p + 64'd4 : 64'd0;
    e.mis    = tk & t[1];
    e.redir  = tk & ~t[1];
    e.tgt    = t;
    return e;
  endfunction

  // Present one instruction for one cycle (called at a negedge).
  task automatic issue(input logic [7:0] op, input logic [63:0] p, input logic [4:0] r,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] i);
    bus.in_valid = 1'b1;
    bus.bj_op = op; bus.pc = p; bus.rd = r;
    bus.data1 = a; bus.data2 = b; bus.imm = i;
    sb.push_back(model(op, p, r, a, b, i));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic got);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Acks on the ack_at-th redirect cycle, counts redirect and flush cycles.
  task automatic drain(input int ack_at, output int rc, output int fc, output logic stable);
    logic [63:0] p0;
    rc = 0; fc = 0; stable = 1'b1; p0 = bus.bj_pc;
    for (int k = 0; k < 20; k++) begin
      if (!bus.bj_en) break;
      rc++;
      if (bus.bj_pc !== p0) stable = 1'b0;
      bus.redirect_ack = (rc >= ack_at);
      @(negedge clk);
      bus.redirect_ack = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      if (!bus.flush) break;
      fc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [201:0] got_v, want_v;
    bus.stall = 0; bus.in_valid = 0; bus.redirect_ack = 0; bus.bj_op = 0;
    bus.pc = 0; bus.rd = 0; bus.data1 = 0; bus.data2 = 0; bus.imm = 0;
    rst_n = 1'b0;
    #12;
    want_v = {1'b0, RST_PC, 5'd0, 64'd0, 1'b0, RST_PC, 3'b000};
    got_v  = {bus.out_valid, bus.out_pc, bus.out_rd, bus.result, bus.bj_en, bus.bj_pc,
              bus.misalign, bus.flush, bus.busy};
    total++;
    if (got_v !== want_v) begin bad++; $display("FAIL reset_state: got %h want %h", got_v, want_v); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    got_v  = {bus.out_valid, bus.out_pc, bus.out_rd, bus.result, bus.bj_en, bus.bj_pc,
              bus.misalign, bus.flush, bus.busy};
    total++;
    if (got_v !== want_v) begin bad++; $display("FAIL post_reset_idle: got %h want %h", got_v, want_v); end
  endtask

  task automatic test_beq;
    logic got, st; int rc, fc; exp_t e;
    issue(8'h80, 64'h1000, 5'd3, 64'd5, 64'd5, 64'h20);
    collect(got);
    total++;
    if (!got) begin bad++; $display("FAIL beq_out_valid: got 0 want 1"); return; end
    e = sb.pop_front();
    total++;
    if ({bus.out_pc, bus.out_rd, bus.result, bus.misalign, bus.bj_en} !== {e.pc, e.rd, e.result, e.mis, e.redir}) begin
      bad++; $display("FAIL beq_outcome: got %h/%0d/%h/%b/%b want %h/%0d/%h/%b/%b", bus.out_pc, bus.out_rd,
                      bus.result, bus.misalign, bus.bj_en, e.pc, e.rd, e.result, e.mis, e.redir);
    end
    total++;
    if (bus.bj_pc !== 64'h1020) begin bad++; $display("FAIL beq_bj_pc: got %h want %h", bus.bj_pc, 64'h1020); end
    drain(3, rc, fc, st);
    total++;
    if (rc !== 3 || st !== 1'b1) begin bad++; $display("FAIL beq_redirect_hold: got %0d cycles stable=%b want 3 stable=1", rc, st); end
    total++;
    if (fc !== FLUSH_D) begin bad++; $display("FAIL beq_flush_len: got %0d want %0d", fc, FLUSH_D); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL beq_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_blt_bltu;
    logic got, st; int rc, fc; exp_t e;
    issue(8'h20, 64'h2000, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40);
    collect(got);
    total++;
    if (!got) begin bad++; $display("FAIL blt_out_valid: got 0 want 1"); return; end
    e = sb.pop_front();
    total++;
    if ({bus.bj_en, bus.bj_pc} !== {e.redir, e.tgt}) begin
      bad++; $display("FAIL blt_taken: got %b/%h want %b/%h", bus.bj_en, bus.bj_pc, e.redir, e.tgt);
    end
    drain(1, rc, fc, st);
    total++;
    if (rc !== 1 || fc !== FLUSH_D) begin bad++; $display("FAIL blt_drain: got %0d/%0d want 1/%0d", rc, fc, FLUSH_D); end
    issue(8'h08, 64'h2100, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40);
    collect(got);
    total++;
    if (!got) begin bad++; $display("FAIL bltu_out_valid: got 0 want 1"); return; end
    e = sb.pop_front();
    total++;
    if ({bus.out_pc, bus.bj_en, bus.bj_pc, bus.result} !== {e.pc, e.redir, 64'h2040, e.result}) begin
      bad++; $display("FAIL bltu_not_taken: got %h/%b/%h/%h want %h/%b/%h/%h", bus.out_pc, bus.bj_en, bus.bj_pc,
                      bus.result, e.pc, e.redir, 64'h2040, e.result);
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.busy, bus.bj_en} !== 3'b000) begin
      bad++; $display("FAIL bltu_idle: got %b want 000", {bus.out_valid, bus.busy, bus.bj_en});
    end
    issue(8'h82, 64'h2200, 5'd6, 64'd9, 64'd9, 64'h10);
    collect(got);
    e = sb.pop_front();
    total++;
    if ({got, bus.bj_en, bus.result, bus.busy} !== {1'b1, e.redir, e.result, 1'b0}) begin
      bad++; $display("FAIL illegal_op: got %b/%b/%h/%b want 1/%b/%h/0", got, bus.bj_en, bus.result, bus.busy,
                      e.redir, e.result);
    end
  endtask

  task automatic test_jalr_misalign;
    logic got; exp_t e;
    issue(8'h01, 64'h3000, 5'd1, 64'h2003, 64'd0, 64'd0);
    collect(got);
    total++;
    if (!got) begin bad++; $display("FAIL jalr_out_valid: got 0 want 1"); return; end
    e = sb.pop_front();
    total++;
    if ({bus.out_rd, bus.result, bus.misalign, bus.bj_en, bus.bj_pc} !== {e.rd, e.result, e.mis, e.redir, e.tgt}) begin
      bad++; $display("FAIL jalr_misalign: got %0d/%h/%b/%b/%h want %0d/%h/%b/%b/%h", bus.out_rd, bus.result,
                      bus.misalign, bus.bj_en, bus.bj_pc, e.rd, e.result, e.mis, e.redir, e.tgt);
    end
    @(negedge clk);
    total++;
    if ({bus.misalign, bus.busy, bus.bj_en} !== 3'b000) begin
      bad++; $display("FAIL jalr_pulse: got %b want 000", {bus.misalign, bus.busy, bus.bj_en});
    end
  endtask

  task automatic test_jal_wrap;
    logic got, st; int rc, fc; exp_t e;
    issue(8'h02, 64'hFFFF_FFFF_FFFF_FFFC, 5'd2, 64'd0, 64'd0, 64'd8);
    collect(got);
    total++;
    if (!got) begin bad++; $display("FAIL jal_out_valid: got 0 want 1"); return; end
    e = sb.pop_front();
    total++;
    if ({bus.result, bus.bj_pc, bus.bj_en} !== {e.result, e.tgt, e.redir}) begin
      bad++; $display("FAIL jal_wrap: got %h/%h/%b want %h/%h/%b", bus.result, bus.bj_pc, bus.bj_en,
                      e.result, e.tgt, e.redir);
    end
    drain(1, rc, fc, st);
    total++;
    if (rc !== 1 || fc !== FLUSH_D) begin bad++; $display("FAIL jal_drain: got %0d/%0d want 1/%0d", rc, fc, FLUSH_D); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bus.in_valid = 1'b1; bus.bj_op = 8'h10; bus.pc = 64'h5000; bus.rd = 5'd7;
    bus.data1 = 64'd5; bus.data2 = 64'd5; bus.imm = 64'h10;
    sb.push_back(model(8'h10, 64'h5000, 5'd7, 64'd5, 64'd5, 64'h10));
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.out_valid, bus.bj_en, bus.bj_pc} !== {1'b1, e.redir, e.tgt}) begin
      bad++; $display("FAIL b2b_first: got %b/%b/%h want 1/%b/%h", bus.out_valid, bus.bj_en, bus.bj_pc, e.redir, e.tgt);
    end
    bus.redirect_ack = 1'b1;
    bus.bj_op = 8'h40; bus.pc = 64'h6000; bus.rd = 5'd8;
    bus.data1 = 64'd7; bus.data2 = 64'd7; bus.imm = 64'h4;
    sb.push_back(model(8'h40, 64'h6000, 5'd8, 64'd7, 64'd7, 64'h4));
    @(negedge clk);
    bus.redirect_ack = 1'b0;
    total++;
    if ({bus.flush, bus.bj_en, bus.out_valid} !== 3'b100) begin
      bad++; $display("FAIL b2b_same_cycle_ack: got %b want 100", {bus.flush, bus.bj_en, bus.out_valid});
    end
    @(negedge clk);
    total++;
    if ({bus.flush, bus.out_valid} !== 2'b10) begin
      bad++; $display("FAIL b2b_flush2: got %b want 10", {bus.flush, bus.out_valid});
    end
    @(negedge clk);
    total++;
    if ({bus.flush, bus.busy, bus.out_valid} !== 3'b000) begin
      bad++; $display("FAIL b2b_no_early_capture: got %b want 000", {bus.flush, bus.busy, bus.out_valid});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if ({bus.out_valid, bus.out_pc, bus.out_rd, bus.bj_en} !== {1'b1, e.pc, e.rd, e.redir}) begin
      bad++; $display("FAIL b2b_second: got %b/%h/%0d/%b want 1/%h/%0d/%b", bus.out_valid, bus.out_pc, bus.out_rd,
                      bus.bj_en, e.pc, e.rd, e.redir);
    end
  endtask

  task automatic test_reset_in_flush;
    logic got;
    issue(8'h80, 64'h7000, 5'd9, 64'd1, 64'd1, 64'd8);
    collect(got);
    void'(sb.pop_front());
    bus.redirect_ack = 1'b1;
    @(negedge clk);
    bus.redirect_ack = 1'b0;
    total++;
    if (bus.flush !== 1'b1) begin bad++; $display("FAIL rst_pre_flush: got %b want 1", bus.flush); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.flush, bus.bj_en, bus.busy, bus.bj_pc, bus.out_pc} !== {3'b000, RST_PC, RST_PC}) begin
      bad++; $display("FAIL rst_in_flush: got %b/%h/%h want 000/%h/%h", {bus.flush, bus.bj_en, bus.busy},
                      bus.bj_pc, bus.out_pc, RST_PC, RST_PC);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.flush, bus.bj_en, bus.busy, bus.out_valid} !== 4'b0000) begin
      bad++; $display("FAIL rst_after_release: got %b want 0000", {bus.flush, bus.bj_en, bus.busy, bus.out_valid});
    end
  endtask

`ifdef BJ_STATS_EN
  task automatic test_stats;
    logic got, st; int rc, fc;
    rst_n = 1'b0; #3; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    issue(8'h80, 64'h100, 5'd1, 64'd3, 64'd3, 64'h40);
    collect(got); void'(sb.pop_front()); drain(1, rc, fc, st);
    issue(8'h40, 64'h200, 5'd1, 64'd3, 64'd3, 64'h40);
    collect(got); void'(sb.pop_front());
    issue(8'h02, 64'h300, 5'd1, 64'd0, 64'd0, 64'h80);
    collect(got); void'(sb.pop_front()); drain(1, rc, fc, st);
    issue(8'h04, 64'h400, 5'd1, 64'd1, 64'd2, 64'h40);
    collect(got); void'(sb.pop_front());
    issue(8'h20, 64'h500, 5'd1, 64'd1, 64'd2, 64'h40);
    collect(got); void'(sb.pop_front()); drain(1, rc, fc, st);
    @(negedge clk);
    total++;
    if (bus.stat_taken !== 32'd3) begin bad++; $display("FAIL stat_taken: got %0d want 3", bus.stat_taken); end
    total++;
    if (bus.stat_nottaken !== 32'd2) begin bad++; $display("FAIL stat_nottaken: got %0d want 2", bus.stat_nottaken); end
    total++;
    if (bus.stat_mispredict_cycles !== 32'(3 * (1 + FLUSH_D))) begin
      bad++; $display("FAIL stat_mispredict: got %0d want %0d", bus.stat_mispredict_cycles, 3 * (1 + FLUSH_D));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_jalr_misalign();
    test_jal_wrap();
    test_back_to_back();
    test_reset_in_flush();
`ifdef BJ_STATS_EN
    test_stats();
`endif
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
